// File: rtl/versat_pkg.sv
// Shared Versat definitions: datapath FSM state encoding and common constants.
package versat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // A programmed period of 0 is promoted to this value.
  localparam int PERIOD_MIN = 1;

endpackage

// File: rtl/delayed_accum_if.sv
// Control/data bundle between the Versat controller (master) and a delayed_accum unit (slave).
interface delayed_accum_if #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  import versat_pkg::*;

  // run is a single-cycle start pulse that samples delay0/iter0/period0 on that edge;
  // running is a level enable; done is a level that is high whenever no operation is in flight.
  logic               running;
  logic               run;
  logic               done;
  logic [DATA_W-1:0]  in0;
  logic [DELAY_W-1:0] delay0;
  logic [CNT_W-1:0]   iter0;
  logic [CNT_W-1:0]   period0;
  logic [DATA_W-1:0]  out0;
  state_t             state;

  modport master (
    output running, run, in0, delay0, iter0, period0,
    input  done, out0, state
  );

  modport slave (
    input  running, run, in0, delay0, iter0, period0,
    output done, out0, state
  );

endinterface

// File: rtl/versat_countdown.sv
// Loadable down-counter that holds at zero; load has priority over enable.
module versat_countdown #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/delayed_accum.sv
// Versat delayed accumulator: after delay0 running cycles, sums iter0 samples of in0 spaced period0 apart.
// Define DELAYED_ACCUM_SATURATE_EN for a signed saturating add instead of a wrapping one.
module delayed_accum
  import versat_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  delayed_accum_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q;
  logic               done_q;
  logic [CNT_W-1:0]   period_q;

  logic               sample, finish, d_en, p_en;
  logic [DELAY_W-1:0] d_count;
  logic               d_zero;
  logic [CNT_W-1:0]   p_count, s_count;
  logic               p_zero, s_zero;
  logic [DATA_W-1:0]  sum_raw, add_res;

  versat_countdown #(.W(DELAY_W)) u_delay (
    .clk(clk), .rst(rst),
    .load(bus.run), .load_val(bus.delay0), .en(d_en),
    .count(d_count), .zero(d_zero)
  );

  // Phase is cleared by run, so ACCUM always opens with an immediate sample.
  versat_countdown #(.W(CNT_W)) u_phase (
    .clk(clk), .rst(rst),
    .load(bus.run | sample), .load_val(bus.run ? '0 : period_q - CNT_W'(1)), .en(p_en),
    .count(p_count), .zero(p_zero)
  );

  versat_countdown #(.W(CNT_W)) u_samples (
    .clk(clk), .rst(rst),
    .load(bus.run), .load_val(bus.iter0), .en(sample),
    .count(s_count), .zero(s_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    finish  = 1'b0;
    d_en    = 1'b0;
    p_en    = 1'b0;
    if (bus.run) begin
      // With no delay the first sample edge is the very next one.
      state_d = (bus.delay0 == '0) ? ACCUM : DELAY;
    end else if (bus.running) begin
      case (state_q)
        DELAY: begin
          d_en = 1'b1;
          if (d_zero || d_count == DELAY_W'(1)) begin
            state_d = s_zero ? IDLE : ACCUM;
            finish  = s_zero;
          end
        end
        ACCUM: begin
          if (s_zero) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else if (p_zero) begin
            sample = 1'b1;
            if (s_count == CNT_W'(1)) begin
              state_d = IDLE;
              finish  = 1'b1;
            end
          end else begin
            p_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sum_raw = acc_q + bus.in0;

`ifdef DELAYED_ACCUM_SATURATE_EN
  // Same-sign operands producing an opposite-sign result mean signed overflow.
  always_comb begin
    add_res = sum_raw;
    if (!acc_q[MSB] && !bus.in0[MSB] && sum_raw[MSB]) begin
      add_res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc_q[MSB] && bus.in0[MSB] && !sum_raw[MSB]) begin
      add_res = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  assign add_res = sum_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      done_q   <= 1'b1;
      period_q <= '0;
    end else if (bus.run) begin
      acc_q    <= '0;
      done_q   <= 1'b0;
      period_q <= (bus.period0 < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : bus.period0;
    end else begin
      if (sample) acc_q  <= add_res;
      if (finish) done_q <= 1'b1;
    end
  end

  assign bus.out0  = acc_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_delayed_accum.sv
// Directed scoreboard bench for delayed_accum with an 8-bit datapath.
module tb_delayed_accum;
  import versat_pkg::*;

  localparam int DW = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   n_run;
  int   n_fail;
  logic finishing;
  logic report_done;
  logic done_prev;

  logic [DW-1:0] exp_q[$];
  int            exp_edge_q[$];
  string         name_q[$];
  logic [DW+2:0] dir_q[$];
  logic [DW-1:0] samp [8];

  delayed_accum_if #(.DELAY_W(32), .DATA_W(DW), .CNT_W(16)) bus ();

  delayed_accum #(.DELAY_W(32), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  // driver: issue one operation; stop_at>0 abandons it after that many edges without a check
  task automatic do_op(input int d, input int n, input int p, input int fs, input int fl,
                       input int stop_at, input logic [DW-1:0] exp_val, input int exp_off,
                       input string name);
    int t, pe, eff, last_j, k;
    logic frozen;
    pe = (p == 0) ? 1 : p;
    @(negedge clk);
    bus.run     = 1'b1;
    bus.running = 1'b1;
    bus.delay0  = 32'(d);
    bus.iter0   = 16'(n);
    bus.period0 = 16'(p);
    bus.in0     = DW'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    t = cyc;
    bus.run = 1'b0;
    if (stop_at == 0) begin
      exp_q.push_back(exp_val);
      exp_edge_q.push_back(t + exp_off);
      name_q.push_back(name);
    end
    last_j = (stop_at > 0) ? stop_at : exp_off + 1;
    eff = 0;
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      frozen = (fs > 0) && (j >= fs) && (j < fs + fl);
      bus.running = !frozen;
      bus.in0 = DW'($urandom_range(0, 255));
      if (!frozen) begin
        eff = eff + 1;
        k = (eff - d - 1) / pe;
        if (eff >= d + 1 && ((eff - d - 1) % pe) == 0 && k < n) bus.in0 = samp[k];
      end
    end
  endtask

  task automatic push_idle_check();
    dir_q.push_back({IDLE, 1'b1, {DW{1'b0}}});
  endtask

  // scoreboard / monitor
  initial begin
    logic [DW+2:0] dv;
    logic [DW-1:0] ev;
    int            ee;
    string         nm;
    done_prev   = 1'b1;
    report_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dir_q.size() > 0) begin
        dv = dir_q.pop_front();
        n_run++;
        if ({bus.state, bus.done, bus.out0} !== dv) begin
          n_fail++;
          $display("FAIL idle_check @%0d: state/done/out0 got %0d/%0b/0x%0h required %0d/%0b/0x%0h",
                   cyc, bus.state, bus.done, bus.out0, dv[DW+2:DW+1], dv[DW], dv[DW-1:0]);
        end
      end
      if (bus.done === 1'b1 && done_prev === 1'b0 && rst === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_done @%0d: out0 got 0x%0h, required no completion", cyc, bus.out0);
        end else begin
          ev = exp_q.pop_front();
          ee = exp_edge_q.pop_front();
          nm = name_q.pop_front();
          n_run += 2;
          if (bus.out0 !== ev) begin
            n_fail++;
            $display("FAIL %s_value: out0 got 0x%0h required 0x%0h", nm, bus.out0, ev);
          end
          if (cyc != ee) begin
            n_fail++;
            $display("FAIL %s_edge: done rose after edge %0d required %0d", nm, cyc, ee);
          end
        end
      end else if (exp_edge_q.size() > 0 && cyc > exp_edge_q[0] + 4) begin
        ev = exp_q.pop_front();
        ee = exp_edge_q.pop_front();
        nm = name_q.pop_front();
        n_run++;
        n_fail++;
        $display("FAIL %s_timeout: no done by edge %0d, required done at edge %0d", nm, cyc, ee);
      end
      done_prev = bus.done;
      if (finishing && !report_done) begin
        n_run++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d completions outstanding, required 0", exp_q.size());
        end
        report_done = 1'b1;
      end
    end
  end

  // stimulus
  initial begin
    n_run       = 0;
    n_fail      = 0;
    cyc         = 0;
    finishing   = 1'b0;
    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.running = 1'b0;
    bus.in0     = '0;
    bus.delay0  = '0;
    bus.iter0   = '0;
    bus.period0 = '0;

    repeat (2) @(posedge clk);
    #1;
    push_idle_check();
    rst = 1'b0;
    bus.running = 1'b1;
    bus.in0 = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    push_idle_check();

    samp[0] = 8'd1; samp[1] = 8'd2; samp[2] = 8'd3; samp[3] = 8'd4;
    do_op(3, 4, 1, 0, 0, 0, 8'd10, 7, "basic");
    do_op(3, 4, 0, 0, 0, 0, 8'd10, 7, "period0");

    samp[0] = 8'd5; samp[1] = 8'd6;
    do_op(2, 2, 3, 0, 0, 0, 8'd11, 6, "period3");
    do_op(2, 0, 1, 0, 0, 0, 8'd0, 2, "iter0");

    samp[0] = 8'h21;
    do_op(0, 1, 1, 0, 0, 0, 8'h21, 1, "nodelay");

    samp[0] = 8'h10; samp[1] = 8'h20;
    do_op(6, 2, 2, 3, 5, 0, 8'h30, 14, "freeze");

    samp[0] = 8'd1; samp[1] = 8'd2; samp[2] = 8'd3; samp[3] = 8'd4;
    do_op(2, 4, 1, 0, 0, 4, 8'd0, 0, "abandoned");
    samp[0] = 8'd7; samp[1] = 8'd8; samp[2] = 8'd9;
    do_op(1, 3, 2, 0, 0, 0, 8'd24, 6, "restart");

    samp[0] = 8'h7F; samp[1] = 8'h7F;
`ifdef DELAYED_ACCUM_SATURATE_EN
    do_op(1, 2, 1, 0, 0, 0, 8'h7F, 3, "ovf_pos");
`else
    do_op(1, 2, 1, 0, 0, 0, 8'hFE, 3, "ovf_pos");
`endif
    samp[0] = 8'h80; samp[1] = 8'h80;
`ifdef DELAYED_ACCUM_SATURATE_EN
    do_op(1, 2, 1, 0, 0, 0, 8'h80, 3, "ovf_neg");
`else
    do_op(1, 2, 1, 0, 0, 0, 8'h00, 3, "ovf_neg");
`endif

    samp[0] = 8'd9; samp[1] = 8'd9; samp[2] = 8'd9; samp[3] = 8'd9;
    do_op(1, 5, 1, 0, 0, 4, 8'd0, 0, "interrupted");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_idle_check();
    @(posedge clk);
    #1;
    rst = 1'b0;

    samp[0] = 8'd3; samp[1] = 8'd4; samp[2] = 8'd5;
    do_op(2, 3, 1, 0, 0, 0, 8'd12, 5, "after_reset");

    repeat (8) @(negedge clk);
    finishing = 1'b1;
    for (int w = 0; w < 10 && !report_done; w++) @(negedge clk);
    if (!report_done) begin
      n_run++;
      n_fail++;
      $display("FAIL report: monitor did not drain, required drain within 10 cycles");
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
